// File: rtl/load_store_unit_pkg.sv
// rtl/load_store_unit_pkg.sv - shared funct3 codes, FSM state encoding and request decode helpers
package load_store_unit_pkg;

    // RV32I load/store size codes (stores share the low three codes)
    localparam logic [2:0] LSU_LB  = 3'b000;
    localparam logic [2:0] LSU_LH  = 3'b001;
    localparam logic [2:0] LSU_LW  = 3'b010;
    localparam logic [2:0] LSU_LBU = 3'b100;
    localparam logic [2:0] LSU_LHU = 3'b101;
    localparam logic [2:0] LSU_SB  = 3'b000;
    localparam logic [2:0] LSU_SH  = 3'b001;
    localparam logic [2:0] LSU_SW  = 3'b010;

    // Byte offset inside a memory word
    localparam int LSU_LANE_SEL_W = 2;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD    = 3'd1,
        S_MERGE = 3'd2,
        S_WR    = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } lsu_state_t;

    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        if (we)
            return (f3 == LSU_SB) || (f3 == LSU_SH) || (f3 == LSU_SW);
        return (f3 == LSU_LB) || (f3 == LSU_LH) || (f3 == LSU_LW) ||
               (f3 == LSU_LBU) || (f3 == LSU_LHU);
    endfunction

    // Halfword needs addr[0]=0, word needs addr[1:0]=0; bytes are never misaligned
    function automatic logic f3_misaligned(input logic [2:0] f3,
                                           input logic [LSU_LANE_SEL_W-1:0] lo);
        case (f3[1:0])
            2'b01:   return lo[0];
            2'b10:   return lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    // Offset with the low bits forced to the natural alignment of the access size
    function automatic logic [LSU_LANE_SEL_W-1:0] align_offset(input logic [2:0] f3,
                                                               input logic [LSU_LANE_SEL_W-1:0] lo);
        case (f3[1:0])
            2'b01:   return {lo[1], 1'b0};
            2'b10:   return 2'b00;
            default: return lo;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_lane.sv
// rtl/load_store_unit_lane.sv - byte/halfword lane extract-extend for loads and merge for stores
//
// Ports:
//   word      old memory word (read data)
//   offset    byte offset of the access inside the word (already aligned)
//   funct3    access size / sign code
//   wdata     right-aligned store data
//   load_data selected lane, sign or zero extended to N bits
//   merged    word with the addressed lane replaced by wdata (whole word for SW)
module load_store_unit_lane
    import load_store_unit_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [N-1:0]                word,
    input  logic [LSU_LANE_SEL_W-1:0]   offset,
    input  logic [2:0]                  funct3,
    input  logic [N-1:0]                wdata,
    output logic [N-1:0]                load_data,
    output logic [N-1:0]                merged
);

    logic [LSU_LANE_SEL_W+2:0] shamt;
    logic [7:0]                lane_byte;
    logic [15:0]               lane_half;
    logic [N-1:0]              lane_mask;

    assign shamt     = {offset, 3'b000};
    assign lane_byte = 8'(word >> shamt);
    assign lane_half = 16'(word >> shamt);

    always_comb begin
        load_data = '0;
        case (funct3)
            LSU_LB:  load_data = {{(N-8){lane_byte[7]}}, lane_byte};
            LSU_LH:  load_data = {{(N-16){lane_half[15]}}, lane_half};
            LSU_LW:  load_data = word;
            LSU_LBU: load_data = {{(N-8){1'b0}}, lane_byte};
            LSU_LHU: load_data = {{(N-16){1'b0}}, lane_half};
            default: load_data = '0;
        endcase
    end

    always_comb begin
        lane_mask = '1;
        case (funct3)
            LSU_SB:  lane_mask = {{(N-8){1'b0}}, 8'hFF} << shamt;
            LSU_SH:  lane_mask = {{(N-16){1'b0}}, 16'hFFFF} << shamt;
            default: lane_mask = '1;
        endcase
    end

    assign merged = (word & ~lane_mask) | ((wdata << shamt) & lane_mask);

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - byte/half/word load-store unit with read-modify-write for sub-word stores
//
// Ports:
//   clk, rstb                       clock and asynchronous active-high reset
//   req_valid/req_ready             request handshake; req_ready only in IDLE
//   req_we, req_funct3, req_addr,   request fields, captured on accept
//   req_wdata
//   resp_valid, resp_rdata,         one-cycle response pulse per accepted request
//   resp_err
//   mem_wrEna, mem_addr, mem_din,   single-port word memory, 1-cycle registered read
//   mem_dout
//
// Configuration: LSU_MISALIGN_TRAP_EN defined -> misaligned requests respond with
// resp_err; undefined -> misaligned requests are force-aligned and proceed.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int N           = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic         clk,
    input  logic         rstb,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_we,
    input  logic [2:0]   req_funct3,
    input  logic [N-1:0] req_addr,
    input  logic [N-1:0] req_wdata,
    output logic         resp_valid,
    output logic [N-1:0] resp_rdata,
    output logic         resp_err,
    output logic         mem_wrEna,
    output logic [N-1:0] mem_addr,
    output logic [N-1:0] mem_din,
    input  logic [N-1:0] mem_dout
);

    generate
        if (MEM_LATENCY != 1) begin : g_latency_check
            $error("load_store_unit: only MEM_LATENCY = 1 is supported");
        end
    endgenerate

    lsu_state_t                 state_q;
    logic                       we_q;
    logic [2:0]                 funct3_q;
    logic [LSU_LANE_SEL_W-1:0]  offset_q;
    logic [N-1:0]               wdata_q;
    logic [N-1:0]               mem_addr_q;

    logic                       req_bad;
    logic [LSU_LANE_SEL_W-1:0]  req_offset;
    logic [N-1:0]               lane_load;
    logic [N-1:0]               lane_merged;

    always_comb begin
        req_bad = !f3_legal(req_we, req_funct3);
`ifdef LSU_MISALIGN_TRAP_EN
        req_bad = req_bad || f3_misaligned(req_funct3, req_addr[LSU_LANE_SEL_W-1:0]);
`endif
    end

    assign req_offset = align_offset(req_funct3, req_addr[LSU_LANE_SEL_W-1:0]);

    always_ff @(posedge clk or posedge rstb) begin
        if (rstb) begin
            state_q    <= S_IDLE;
            we_q       <= 1'b0;
            funct3_q   <= 3'b000;
            offset_q   <= '0;
            wdata_q    <= '0;
            mem_addr_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        we_q     <= req_we;
                        funct3_q <= req_funct3;
                        offset_q <= req_offset;
                        wdata_q  <= req_wdata;
                        if (req_bad) begin
                            // mem_addr_q is left alone so the memory bus stays quiet
                            state_q <= S_ERR;
                        end else begin
                            mem_addr_q <= {req_addr[N-1:2], 2'b00};
                            state_q    <= (req_we && req_funct3 == LSU_SW) ? S_WR : S_RD;
                        end
                    end
                end
                S_RD:    state_q <= we_q ? S_MERGE : S_DONE;
                S_MERGE: state_q <= S_DONE;
                S_WR:    state_q <= S_DONE;
                S_DONE:  state_q <= S_IDLE;
                S_ERR:   state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    load_store_unit_lane #(
        .N (N)
    ) u_lane (
        .word      (mem_dout),
        .offset    (offset_q),
        .funct3    (funct3_q),
        .wdata     (wdata_q),
        .load_data (lane_load),
        .merged    (lane_merged)
    );

    // Write enable is a pure state decode, so an asynchronous reset drops it at once
    assign req_ready  = (state_q == S_IDLE);
    assign mem_addr   = mem_addr_q;
    assign mem_wrEna  = (state_q == S_MERGE) || (state_q == S_WR);
    assign resp_valid = (state_q == S_DONE) || (state_q == S_ERR);
    assign resp_err   = (state_q == S_ERR);
    assign resp_rdata = (state_q == S_DONE && !we_q) ? lane_load : '0;

    always_comb begin
        mem_din = '0;
        case (state_q)
            S_WR:    mem_din = wdata_q;
            S_MERGE: mem_din = lane_merged;
            default: mem_din = '0;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rstb;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_wrEna;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;

    logic [31:0] mem [0:63];

    int checks = 0;
    int errors = 0;

    int          r_lat;
    int          r_writes;
    logic [31:0] r_rdata;
    logic        r_err;
    logic [31:0] r_wdata;
    logic [31:0] r_waddr;
    logic        r_ready_hi;

    always #5 clk = ~clk;

    // Word memory: registered read, read-before-write
    always @(posedge clk) begin
        if (mem_wrEna)
            mem[mem_addr[7:2]] <= mem_din;
        mem_dout <= mem[mem_addr[7:2]];
    end

    load_store_unit #(
        .N           (32),
        .MEM_LATENCY (1)
    ) dut (
        .clk        (clk),
        .rstb       (rstb),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_wrEna  (mem_wrEna),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_dout   (mem_dout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic sample_cycle();
        if (mem_wrEna === 1'b1) begin
            r_writes++;
            r_wdata = mem_din;
            r_waddr = mem_addr;
        end
        if (req_ready === 1'b1)
            r_ready_hi = 1'b1;
    endtask

    // Called from IDLE, #1 after an edge; returns #1 after the edge that re-enters IDLE
    task automatic issue(input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = d;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        r_lat      = 1;
        r_writes   = 0;
        r_ready_hi = 1'b0;
        r_wdata    = '0;
        r_waddr    = '0;
        while (resp_valid !== 1'b1 && r_lat < 10) begin
            sample_cycle();
            @(posedge clk);
            #1;
            r_lat++;
        end
        sample_cycle();
        r_rdata = resp_rdata;
        r_err   = resp_err;
        @(posedge clk);
        #1;
        check("resp_pulse_ends", {31'd0, resp_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rstb       = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = '0;
        req_wdata  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready",  {31'd0, req_ready},  32'd1);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_resp_err",   {31'd0, resp_err},   32'd0);
        check("rst_resp_rdata", resp_rdata,          32'd0);
        check("rst_mem_wrEna",  {31'd0, mem_wrEna},  32'd0);
        check("rst_mem_addr",   mem_addr,            32'd0);
        check("rst_mem_din",    mem_din,             32'd0);
        rstb = 1'b0;
        @(posedge clk);
        #1;

        // Preload word 0x40 through the DUT
        issue(1'b1, 3'b010, 32'h40, 32'h8899AABB);
        check("sw40_lat",    r_lat,    2);
        check("sw40_mem",    mem[16],  32'h8899AABB);

        issue(1'b0, 3'b000, 32'h41, 32'h0);
        check("lb41_lat",    r_lat,    2);
        check("lb41_rdata",  r_rdata,  32'hFFFFFFAA);
        check("lb41_err",    {31'd0, r_err}, 32'd0);
        check("lb41_writes", r_writes, 0);

        issue(1'b0, 3'b100, 32'h41, 32'h0);
        check("lbu41_rdata", r_rdata,  32'h000000AA);

        issue(1'b0, 3'b001, 32'h42, 32'h0);
        check("lh42_rdata",  r_rdata,  32'hFFFF8899);

        issue(1'b0, 3'b101, 32'h42, 32'h0);
        check("lhu42_rdata", r_rdata,  32'h00008899);

        issue(1'b0, 3'b000, 32'h43, 32'h0);
        check("lb43_rdata",  r_rdata,  32'hFFFFFF88);

        issue(1'b0, 3'b100, 32'h40, 32'h0);
        check("lbu40_rdata", r_rdata,  32'h000000BB);

        issue(1'b1, 3'b000, 32'h42, 32'h11);
        check("sb42_lat",    r_lat,    3);
        check("sb42_writes", r_writes, 1);
        check("sb42_wdata",  r_wdata,  32'h8811AABB);
        check("sb42_waddr",  r_waddr,  32'h40);
        check("sb42_rdata",  r_rdata,  32'h0);
        check("sb42_mem",    mem[16],  32'h8811AABB);

        issue(1'b0, 3'b010, 32'h40, 32'h0);
        check("lw40_after_sb", r_rdata, 32'h8811AABB);

        issue(1'b1, 3'b001, 32'h42, 32'hFFFF1234);
        check("sh42_lat",    r_lat,    3);
        check("sh42_wdata",  r_wdata,  32'h1234AABB);

        issue(1'b0, 3'b010, 32'h40, 32'h0);
        check("lw40_after_sh", r_rdata, 32'h1234AABB);

        issue(1'b1, 3'b010, 32'h80, 32'hDEADBEEF);
        check("sw80_lat",      r_lat,    2);
        check("sw80_writes",   r_writes, 1);
        check("sw80_wdata",    r_wdata,  32'hDEADBEEF);
        check("sw80_ready_lo", {31'd0, r_ready_hi}, 32'd0);
        check("sw80_mem",      mem[32],  32'hDEADBEEF);
        check("sw80_ready_back", {31'd0, req_ready}, 32'd1);

        issue(1'b0, 3'b010, 32'h43, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
        check("lw43_err",    {31'd0, r_err}, 32'd1);
        check("lw43_rdata",  r_rdata,  32'h0);
        check("lw43_writes", r_writes, 0);
        check("lw43_lat",    r_lat,    1);
`else
        check("lw43_err",    {31'd0, r_err}, 32'd0);
        check("lw43_rdata",  r_rdata,  32'h1234AABB);
        check("lw43_lat",    r_lat,    2);
`endif

        issue(1'b0, 3'b111, 32'h40, 32'h0);
        check("ld111_err",   {31'd0, r_err}, 32'd1);
        check("ld111_lat",   r_lat,    1);
        check("ld111_rdata", r_rdata,  32'h0);

        issue(1'b1, 3'b011, 32'h80, 32'h12345678);
        check("st011_err",    {31'd0, r_err}, 32'd1);
        check("st011_writes", r_writes, 0);
        check("st011_mem",    mem[32], 32'hDEADBEEF);

        // Sub-word store aborted by reset while in MERGE
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b000;
        req_addr   = 32'h81;
        req_wdata  = 32'h55;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        check("abort_in_merge", {31'd0, mem_wrEna}, 32'd1);
        rstb = 1'b1;
        #1;
        check("abort_wrEna_drop", {31'd0, mem_wrEna}, 32'd0);
        check("abort_ready",      {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        rstb = 1'b0;
        r_ready_hi = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (resp_valid !== 1'b0)
                r_ready_hi = 1'b1;
            @(posedge clk);
            #1;
        end
        check("abort_no_resp", {31'd0, r_ready_hi}, 32'd0);
        check("abort_mem",     mem[32], 32'hDEADBEEF);

        issue(1'b0, 3'b010, 32'h80, 32'h0);
        check("post_abort_lat",   r_lat,   2);
        check("post_abort_rdata", r_rdata, 32'hDEADBEEF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
